// File: rtl/dmi_crc32_stream_if.sv
// Valid/ready beat stream carrying byte lanes plus frame delimiters.
interface dmi_crc32_stream_if #(
  parameter int DATA_BYTES = 2,
  parameter int NBW        = $clog2(DATA_BYTES) + 1
);
  logic                    valid;
  logic                    ready;
  logic [8*DATA_BYTES-1:0] data;
  logic                    sof;
  logic                    eof;
  logic [NBW-1:0]          nbytes;

  modport master (output valid, data, sof, eof, nbytes, input ready);
  modport slave  (input valid, data, sof, eof, nbytes, output ready);
endinterface

// File: rtl/dmi_crc32_stream.sv
// Streaming IEEE 802.3 CRC-32 engine: appends the FCS in generate mode,
// verifies it and forwards the frame unchanged in check mode.
module dmi_crc32_stream #(
  parameter int DATA_BYTES = 2,
  parameter int NBW        = $clog2(DATA_BYTES) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_mode,
  dmi_crc32_stream_if.slave  s_in,
  dmi_crc32_stream_if.master m_out,
  output logic               o_done,
  output logic [31:0]        o_crc,
  output logic               o_crc_err
);
  localparam int          W          = 8 * DATA_BYTES;
  localparam int          TAIL_LANES = (DATA_BYTES < 4) ? DATA_BYTES : 4;
  localparam logic [3:0]  DB         = 4'(DATA_BYTES);
  localparam logic [31:0] POLY       = 32'hEDB88320;
  localparam logic [31:0] RESIDUE    = 32'hDEBB20E3;

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_TAIL} state_t;

  state_t         state_q, state_d;
  logic [31:0]    crc_q, crc_d;
  logic           mode_q, mode_d;
  logic           ovalid_q, ovalid_d;
  logic [W-1:0]   odata_q, odata_d;
  logic           osof_q, osof_d;
  logic           oeof_q, oeof_d;
  logic [NBW-1:0] onb_q, onb_d;
  logic           done_q, done_d;
  logic [31:0]    crc_out_q, crc_out_d;
  logic           err_q, err_d;
  logic [31:0]    fcs_q, fcs_d;
  logic [2:0]     tail_q, tail_d;

  logic           out_adv, in_ready, in_fire, accept_beat, mode_eff, tail_last;
  logic [3:0]     lanes, fcs_fit, tail_cnt;
  logic [31:0]    crc_base, crc_new, fcs_now;
  logic [W-1:0]   gen_data, tail_data;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign out_adv     = !ovalid_q || m_out.ready;
  assign in_ready    = out_adv && (state_q != ST_TAIL);
  assign in_fire     = s_in.valid && in_ready;
  assign accept_beat = in_fire && (s_in.sof || (state_q == ST_FRAME));
  assign mode_eff    = s_in.sof ? i_mode : mode_q;
  assign crc_base    = s_in.sof ? 32'hFFFFFFFF : crc_q;

  // Lanes that carry frame bytes on this beat; nbytes of 0 or too large means a full beat.
  always_comb begin
    lanes = DB;
    if (s_in.eof && (s_in.nbytes != '0) && (32'(s_in.nbytes) <= DATA_BYTES)) begin
      lanes = 4'(s_in.nbytes);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      logic [31:0] crc_in;
      logic [31:0] crc_out;
      if (gi == 0) begin : g_first
        assign crc_in = crc_base;
      end else begin : g_next
        assign crc_in = g_lane[gi-1].crc_out;
      end
      assign crc_out = (4'(gi) < lanes) ? crc_byte(crc_in, s_in.data[W-1-8*gi -: 8]) : crc_in;
    end
  endgenerate

  assign crc_new = g_lane[DATA_BYTES-1].crc_out;
  assign fcs_now = ~crc_new;
  assign fcs_fit = ((DB - lanes) > 4'd4) ? 4'd4 : (DB - lanes);

  // FCS goes out LS byte first, starting in the first unused lane of the eof beat.
  always_comb begin
    gen_data = s_in.data;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if ((j >= int'(lanes)) && (j < int'(lanes) + 4)) begin
        gen_data[W-1-8*j -: 8] = fcs_now[8*(j - int'(lanes)) +: 8];
      end
    end
  end

  assign tail_last = ({1'b0, tail_q} <= DB);
  assign tail_cnt  = tail_last ? {1'b0, tail_q} : DB;

  always_comb begin
    tail_data = '0;
    for (int j = 0; j < TAIL_LANES; j++) begin
      if (4'(j) < tail_cnt) begin
        tail_data[W-1-8*j -: 8] = fcs_q[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    mode_d    = mode_q;
    ovalid_d  = ovalid_q;
    odata_d   = odata_q;
    osof_d    = osof_q;
    oeof_d    = oeof_q;
    onb_d     = onb_q;
    done_d    = 1'b0;
    crc_out_d = crc_out_q;
    err_d     = err_q;
    fcs_d     = fcs_q;
    tail_d    = tail_q;

    if (out_adv) begin
      ovalid_d = 1'b0;
    end

    case (state_q)
      ST_TAIL: begin
        if (out_adv) begin
          ovalid_d = 1'b1;
          odata_d  = tail_data;
          osof_d   = 1'b0;
          oeof_d   = tail_last;
          onb_d    = NBW'(tail_cnt);
          fcs_d    = fcs_q >> W;
          tail_d   = tail_q - 3'(tail_cnt);
          if (tail_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        if (accept_beat) begin
          ovalid_d = 1'b1;
          odata_d  = s_in.data;
          osof_d   = s_in.sof;
          oeof_d   = s_in.eof;
          onb_d    = s_in.nbytes;
          mode_d   = mode_eff;
          crc_d    = crc_new;
          state_d  = ST_FRAME;
          if (s_in.eof) begin
            done_d    = 1'b1;
            crc_out_d = fcs_now;
            err_d     = mode_eff && (crc_new != RESIDUE);
            crc_d     = 32'hFFFFFFFF;
            state_d   = ST_IDLE;
            if (!mode_eff) begin
              odata_d = gen_data;
              if (fcs_fit < 4'd4) begin
                oeof_d  = 1'b0;
                onb_d   = NBW'(DB);
                fcs_d   = fcs_now >> {fcs_fit, 3'b000};
                tail_d  = 3'(4'd4 - fcs_fit);
                state_d = ST_TAIL;
              end else begin
                onb_d = NBW'(lanes + 4'd4);
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= 32'hFFFFFFFF;
      mode_q    <= 1'b0;
      ovalid_q  <= 1'b0;
      odata_q   <= '0;
      osof_q    <= 1'b0;
      oeof_q    <= 1'b0;
      onb_q     <= '0;
      done_q    <= 1'b0;
      crc_out_q <= '0;
      err_q     <= 1'b0;
      fcs_q     <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      mode_q    <= mode_d;
      ovalid_q  <= ovalid_d;
      odata_q   <= odata_d;
      osof_q    <= osof_d;
      oeof_q    <= oeof_d;
      onb_q     <= onb_d;
      done_q    <= done_d;
      crc_out_q <= crc_out_d;
      err_q     <= err_d;
      fcs_q     <= fcs_d;
      tail_q    <= tail_d;
    end
  end

  assign s_in.ready   = in_ready;
  assign m_out.valid  = ovalid_q;
  assign m_out.data   = odata_q;
  assign m_out.sof    = osof_q;
  assign m_out.eof    = oeof_q;
  assign m_out.nbytes = onb_q;
  assign o_done       = done_q;
  assign o_crc        = crc_out_q;
  assign o_crc_err    = err_q;
endmodule

// File: doc/dmi_crc32_stream.md
# dmi_crc32_stream

Parametrised streaming IEEE 802.3 CRC-32 engine for the DMI Ethernet datapath. It sits inline between the frame builder and the MAC transmit path, or between the MAC receive path and the frame parser. The data width (bytes per beat) is set at elaboration. The block handles a partial last beat and applies valid/ready backpressure. In generate mode it appends the FCS to the frame. In check mode it verifies the received FCS and passes data through unchanged.

## Interface
- DATA_BYTES, 2, bytes per beat; legal values 1, 2, 4, 8.
- NBW, $clog2(DATA_BYTES)+1, width of byte-count fields.

- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_mode  in  1  0 = generate/append FCS, 1 = check FCS; sampled on the sof beat.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts the input beat.
- i_data  in  8*DATA_BYTES  beat data; lane 0 = [8*DATA_BYTES-1 -: 8] is the first byte on the wire.
- i_sof  in  1  first beat of frame.
- i_eof  in  1  last beat of frame.
- i_nbytes  in  NBW  valid bytes on the eof beat, occupying lanes 0..n-1; the value 0 or any value above DATA_BYTES means DATA_BYTES.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_data, o_sof, o_eof, o_nbytes  out  as the inputs  output beat.
- o_done  out  1  one-cycle pulse when the frame CRC result is available.
- o_crc  out  32  final FCS value (complemented register).
- o_crc_err  out  1  check mode only: the FCS mismatched.

## Operation
- CRC: reflected polynomial 0x04C11DB7 (0xEDB88320 reflected), init 0xFFFFFFFF, xorout 0xFFFFFFFF. Bytes are processed in lane order, LSB first. The CRC of "123456789" is 0xCBF43926.
- The byte-serial update is unrolled DATA_BYTES times within one cycle. On the eof beat, only lanes 0..n-1 update the CRC.
- States:
  - IDLE: wait for sof. Valid beats without sof are accepted and discarded; no output.
  - FRAME: accept and forward beats.
  - TAIL: generate mode only; emit the FCS bytes that did not fit in the eof beat.
- Transitions:
  - sof & !eof: IDLE → FRAME.
  - eof (FRAME, or sof & eof in IDLE): → TAIL if generate mode and n+4 > DATA_BYTES; otherwise → IDLE.
  - TAIL → IDLE after the last FCS beat is accepted.
- Generate mode, FCS placement:
  - FCS bytes are appended LS byte first, i.e. ~reg[7:0] first.
  - They fill lanes n..DATA_BYTES-1 of the eof beat; the remaining bytes go out in TAIL beats.
  - o_eof and o_nbytes mark the true final byte.
- Check mode:
  - Data, sof, eof and nbytes pass through unchanged.
  - The CRC runs over all bytes, including the FCS.
  - o_crc_err = (register before xorout ≠ 0xDEBB20E3).
- sof arriving in FRAME aborts the current frame: CRC restarts, the beat is forwarded with o_sof, and no o_done is generated for the aborted frame.
- o_crc_err is 0 in generate mode.

## Timing
- Reset values: o_valid 0, o_sof 0, o_eof 0, o_nbytes 0, o_data 0, o_done 0, o_crc 0, o_crc_err 0. State is IDLE and the CRC register is 0xFFFFFFFF. Reset mid-frame drops the frame in flight without emitting eof.
- A single output register stage gives 1-cycle latency from input acceptance to o_valid.
- o_ready = (!o_valid | i_ready) & (state ≠ TAIL). A beat transfers on valid & ready.
- o_valid/o_data hold stable while o_valid & !i_ready.
- o_done pulses in the cycle after the eof input beat is accepted. o_crc and o_crc_err then hold until the next o_done.
- A mode change is honoured only on a sof beat; i_mode is ignored mid-frame.
- TAIL emits one beat per accepted output transfer. After the final TAIL transfer, o_ready rises in the following cycle, so back-to-back frames are supported.

## Test plan
- Generate, DATA_BYTES=2, "123456789" (last beat nbytes=1):
  - Output beats: 3132, 3334, 3536, 3738, 3926, 39F4, CB with nbytes=1 and eof.
  - o_crc = 0xCBF43926; o_ready is low for 2 TAIL cycles.
- Generate, DATA_BYTES=4, same frame:
  - Eof beat = 39 26 39 F4, nbytes 4, no eof; then a tail beat CB, nbytes 1, eof.
- Generate, single-beat frame (sof & eof, byte 0x00, nbytes=1):
  - FCS bytes 8D EF 02 D2; o_crc = 0xD202EF8D.
- Check mode, the 13-byte frame from the first scenario:
  - o_crc_err = 0, output identical to input.
  - With one data bit flipped: o_crc_err = 1.
- Random i_ready backpressure (50%) over 100 random frames:
  - No beat lost or duplicated; data stable while stalled.
  - The check-mode loopback of the generated frames reports no errors.
- i_rst asserted mid-frame: next cycle o_valid = 0 and state IDLE. A following frame produces a correct FCS.
- sof asserted mid-frame: no o_done for the aborted frame, and a correct FCS for the new frame.
